// File: rtl/element_row_accumulator_pkg.sv
// Shared types and defaults for the element row accumulator.
// Holds the FSM state encoding and the default geometry.
package element_row_accumulator_pkg;
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_SUM_W   = 16;
    localparam int DEF_ROW_LEN = 4;
    localparam int DEF_IDX_W   = 4;
endpackage

// File: rtl/element_acc_reg.sv
// SUM_W-bit accumulator with carry-out into a sticky overflow flag; clear beats enable.
// Latency: one cycle per update; no flow control of its own.
// Backpressure: none; the caller gates en.
module element_acc_reg #(
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SUM_W-1:0] din,
    output logic [SUM_W-1:0] sum_nxt,
    output logic             ovf_nxt
);
    logic [SUM_W-1:0] acc;
    logic             ovf;
    logic [SUM_W:0]   wide;

    assign wide    = {1'b0, acc} + {1'b0, din};
    assign sum_nxt = wide[SUM_W-1:0];
    assign ovf_nxt = ovf | wide[SUM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= sum_nxt;
            ovf <= ovf_nxt;
        end
    end
endmodule

// File: rtl/element_row_accumulator.sv
// Sums ROW_LEN element sums into a row total, reported with a valid/ready handshake.
// Latency: row result valid the cycle after its last element is accepted.
// Backpressure: in_ready drops while a row result waits for out_ready.
module element_row_accumulator
    import element_row_accumulator_pkg::*;
#(
    parameter int ROW_LEN = DEF_ROW_LEN,
    parameter int SUM_W   = DEF_SUM_W,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_row_sum,
    output logic [IDX_W-1:0] out_row_idx,
    output logic             out_ovf
);
    localparam int CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] elem_cnt;
    logic [IDX_W-1:0] row_idx;
    logic             accept;
    logic             out_fire;
    logic             acc_clr;
    logic             acc_en;
    logic [SUM_W-1:0] sum_nxt;
    logic             ovf_nxt;

    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready;
    assign out_fire = (state == HOLD) && out_valid && out_ready;
    // Flush wins over a same-cycle element; a held row cannot be flushed.
    assign acc_clr  = ((state == ACC) && flush) || out_fire;
    assign acc_en   = accept && !flush;

    element_acc_reg #(.SUM_W(SUM_W)) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .din     (in_sum),
        .sum_nxt (sum_nxt),
        .ovf_nxt (ovf_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            elem_cnt    <= '0;
            row_idx     <= '0;
            out_valid   <= 1'b0;
            out_row_sum <= '0;
            out_row_idx <= '0;
            out_ovf     <= 1'b0;
        end else if (state == ACC) begin
            if (flush) begin
                elem_cnt <= '0;
            end else if (accept) begin
                elem_cnt <= elem_cnt + 1'b1;
                if (elem_cnt == LAST) begin
                    out_row_sum <= sum_nxt;
                    out_ovf     <= ovf_nxt;
                    out_row_idx <= row_idx;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
            elem_cnt  <= '0;
            row_idx   <= row_idx + 1'b1;
            state     <= ACC;
        end
    end
endmodule

// File: tb/tb_element_row_accumulator.sv
// Self-checking bench: directed scenarios plus randomized rows against a row-level model.
module tb_element_row_accumulator;
    localparam int ROW_LEN = 4;
    localparam int SUM_W   = 16;
    localparam int IDX_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_row_sum;
    logic [IDX_W-1:0] out_row_idx;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    // Row-level model: true (unbounded) sum of the row; overflow means it reached 2^SUM_W.
    longint           m_total = 0;
    int               m_cnt = 0;
    int               m_idx = 0;
    bit               m_pend = 0;
    logic [SUM_W-1:0] e_sum = '0;
    logic [IDX_W-1:0] e_idx = '0;
    logic             e_ovf = 1'b0;

    element_row_accumulator #(.ROW_LEN(ROW_LEN), .SUM_W(SUM_W), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_sum (out_row_sum),
        .out_row_idx (out_row_idx),
        .out_ovf     (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_accept(input logic [SUM_W-1:0] v);
        m_total += longint'(v);
        m_cnt++;
        if (m_cnt == ROW_LEN) begin
            e_sum  = m_total[SUM_W-1:0];
            e_ovf  = (m_total >= 64'd65536);
            e_idx  = IDX_W'(m_idx);
            m_pend = 1;
        end
    endtask

    task automatic model_release();
        m_pend  = 0;
        m_idx   = (m_idx + 1) % (1 << IDX_W);
        m_total = 0;
        m_cnt   = 0;
    endtask

    task automatic model_reset();
        m_pend = 0; m_idx = 0; m_total = 0; m_cnt = 0;
    endtask

    // Starts and ends on a falling edge; in_valid is low on return.
    task automatic push(input logic [SUM_W-1:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_sum   = v;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            @(posedge clk);
            model_accept(v);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic release_row();
        bit fire;
        out_ready = 1'b1;
        fire = out_valid;
        @(posedge clk);
        if (fire) model_release();
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_row_sum !== 16'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", out_row_sum); end
        checks++; if (out_row_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_row_idx); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [SUM_W-1:0] row0 [4] = '{16'd3, 16'd5, 16'd7, 16'd30};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(row0[i]);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        checks++; if (out_row_sum !== 16'd45) begin errors++; $display("FAIL b2b_sum: got %0d want 45", out_row_sum); end
        checks++; if (out_row_idx !== 4'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_idx_ovf: got %0d/%b want 0/0", out_row_idx, out_ovf); end
        @(posedge clk);
        model_release();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_after: valid %b ready %b want 0 1", out_valid, in_ready); end
        for (int i = 0; i < 4; i++) push(SUM_W'(i + 1));
        checks++; if (out_row_idx !== 4'd1 || out_row_sum !== 16'd10) begin errors++; $display("FAIL b2b_row1: idx %0d sum %0d want 1 10", out_row_idx, out_row_sum); end
        @(posedge clk);
        model_release();
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        push(16'hFFF0); push(16'h0020); push(16'h0000); push(16'h0000);
        checks++; if (out_row_sum !== 16'h0010 || out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_row: sum %h ovf %b want 0010 1", out_row_sum, out_ovf); end
        release_row();
        for (int i = 0; i < 4; i++) push(16'd1);
        checks++; if (out_row_sum !== 16'd4 || out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: sum %0d ovf %b want 4 0", out_row_sum, out_ovf); end
        release_row();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push(16'd3);
        in_valid = 1'b1;
        in_sum   = 16'd7;
        for (int c = 0; c < 5; c++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row_sum !== 16'd12) begin
                errors++; $display("FAIL bp_hold: cyc %0d ready %b valid %b sum %0d want 0 1 12", c, in_ready, out_valid, out_row_sum);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        model_release();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: ready %b valid %b want 1 0", in_ready, out_valid); end
        for (int i = 0; i < 4; i++) push(16'd2);
        checks++; if (out_row_sum !== 16'd8 || out_row_idx !== e_idx) begin errors++; $display("FAIL bp_next: sum %0d idx %0d want 8 %0d", out_row_sum, out_row_idx, e_idx); end
        release_row();
    endtask

    task automatic test_flush();
        logic [IDX_W-1:0] idx_before;
        idx_before = IDX_W'(m_idx);
        push(16'd10); push(16'd20);
        flush = 1'b1; in_valid = 1'b1; in_sum = 16'd99;
        @(posedge clk);
        m_total = 0; m_cnt = 0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) push(SUM_W'(i + 1));
        checks++; if (out_row_sum !== 16'd10 || out_row_idx !== idx_before) begin errors++; $display("FAIL flush_row: sum %0d idx %0d want 10 %0d", out_row_sum, out_row_idx, idx_before); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_row_sum !== 16'd10) begin errors++; $display("FAIL flush_hold: valid %b sum %0d want 1 10", out_valid, out_row_sum); end
        release_row();
    endtask

    task automatic test_reset_mid();
        push(16'd5); push(16'd6);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: ready %b valid %b want 1 0", in_ready, out_valid); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push(16'd9); push(16'd9); push(16'd9); push(16'd9);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_row_sum !== 16'd0) begin errors++; $display("FAIL rst_hold: valid %b sum %0d want 0 0", out_valid, out_row_sum); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(16'd1);
        checks++; if (out_row_idx !== 4'd0 || out_row_sum !== 16'd4) begin errors++; $display("FAIL rst_next: idx %0d sum %0d want 0 4", out_row_idx, out_row_sum); end
        release_row();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 17; r++) begin
            for (int i = 0; i < 4; i++) push(16'd1);
            checks++; if (out_row_idx !== IDX_W'(r % 16) || out_row_sum !== 16'd4) begin
                errors++; $display("FAIL wrap_row%0d: idx %0d sum %0d want %0d 4", r, out_row_idx, out_row_sum, r % 16);
            end
            release_row();
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            while (!m_pend) begin
                logic [SUM_W-1:0] v;
                v = ($urandom_range(0, 3) == 0) ? SUM_W'($urandom) : SUM_W'($urandom_range(0, 300));
                if ($urandom_range(0, 9) == 0 && m_cnt > 0) begin
                    flush = 1'b1; in_valid = 1'b1; in_sum = v;
                    @(posedge clk);
                    m_total = 0; m_cnt = 0;
                    @(negedge clk);
                    flush = 1'b0; in_valid = 1'b0;
                end else begin
                    push(v);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_row_sum !== e_sum || out_row_idx !== e_idx || out_ovf !== e_ovf) begin
                errors++; $display("FAIL rand_row%0d: v%b sum %h idx %0d ovf %b want 1 %h %0d %b", r, out_valid, out_row_sum, out_row_idx, out_ovf, e_sum, e_idx, e_ovf);
            end
            release_row();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/element_row_accumulator.md
Name: element_row_accumulator

Overview:
- Downstream stage of the one-hot element adder. Consumes its 16-bit per-element sums (index of operand A plus index of operand B) as a stream.
- Accumulates ROW_LEN consecutive sums into one row total and presents it with a valid/ready handshake to the matrix result path.
- Adds the sequencing, backpressure and per-row bookkeeping that the purely combinational adder stage lacks.

Parameters:
- ROW_LEN, 4, elements per row; legal range 2..256.
- SUM_W, 16, width of input sum and accumulator; matches the adder output width.
- IDX_W, 4, width of the row index counter; wraps modulo 2^IDX_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_sum holds a valid element sum.
- in_ready  output  1  block can accept an element this cycle.
- in_sum  input  SUM_W  element sum from the adder; bit 0 is the LSB (adder output p0).
- flush  input  1  synchronous pulse; discards the partial row.
- out_valid  output  1  row result is valid.
- out_ready  input  1  consumer accepts the row result.
- out_row_sum  output  SUM_W  accumulated row total, modulo 2^SUM_W.
- out_row_idx  output  IDX_W  index of the row being reported.
- out_ovf  output  1  sticky: a carry out of the accumulator occurred during this row.

Behaviour:
- Interface timing: one clock, clk. Reset is asynchronous and active-low (rst_n). Asserting rst_n low immediately forces:
  - state to ACC; acc=0; elem_cnt=0; row_idx=0; ovf=0;
  - out_valid=0; out_row_sum=0; out_row_idx=0; out_ovf=0; in_ready=1 one cycle after deassertion (and combinationally from ACC).
- Input handshake:
  - An element is accepted on an edge where in_valid and in_ready are both 1.
  - in_ready=1 only in state ACC.
- State ACC:
  - On acceptance: {carry, acc} <= acc + in_sum at SUM_W+1 bits; ovf <= ovf | carry; elem_cnt <= elem_cnt + 1.
  - On acceptance with elem_cnt == ROW_LEN-1:
    - out_row_sum <= final sum, out_ovf <= final ovf, out_row_idx <= row_idx;
    - out_valid <= 1; go to HOLD.
    - Latency: last element accepted at edge t gives out_valid high after edge t (visible in cycle t+1).
  - flush=1 in ACC: acc, elem_cnt and ovf are cleared at the next edge. Any element accepted in the same cycle is discarded, because flush has priority. row_idx is unchanged.
- State HOLD:
  - in_ready=0. out_valid=1, and out_row_sum, out_row_idx and out_ovf are held stable until accepted.
  - On out_valid and out_ready at an edge:
    - out_valid <= 0; acc, elem_cnt and ovf are cleared;
    - row_idx <= row_idx + 1, wrapping from 2^IDX_W-1 to 0;
    - go to ACC. The first element of the next row is accepted no earlier than the following cycle.
  - flush in HOLD is ignored. A completed row is never discarded.
- Arithmetic:
  - Unsigned and modulo 2^SUM_W; no saturation.
  - out_ovf reports whether any wrap occurred within the row.
- Outputs: all outputs are registered except in_ready, which is decoded from state.
- Reset mid-row: the partial row is lost and row_idx returns to 0.
- Reset in HOLD: the pending result is dropped and out_valid goes low immediately.

Decomposition:
- Shared package: state encoding (ACC=1'b0, HOLD=1'b1), default SUM_W=16, default ROW_LEN=4.
- One natural sub-module: element_acc_reg, an SUM_W-bit accumulator register with carry-out, sticky overflow and synchronous clear.
- The FSM, element counter and row counter live in the top module.

Test Plan:
- Basic row: ROW_LEN=4. Send 3, 5, 7, 30 back-to-back with out_ready=1 → one cycle after the 4th element, out_valid=1, out_row_sum=45, out_row_idx=0, out_ovf=0; next row reports row_idx=1.
- Overflow: send 16'hFFF0, 16'h0020, 0, 0 → out_row_sum=16'h0010, out_ovf=1. The next row of 1, 1, 1, 1 gives out_row_sum=4, out_ovf=0.
- Backpressure: complete a row summing to 12, hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, outputs stable at 12, no element accepted; out_ready=1 releases, and in_ready returns to 1 the next cycle.
- Flush: accept 10 and 20, then pulse flush with in_valid=1 and in_sum=99, then send 1, 2, 3, 4 → out_row_sum=10 and row_idx unchanged. Also pulse flush in HOLD → result still delivered.
- Reset mid-row and in HOLD: drop rst_n asynchronously after 2 elements and again while out_valid=1 → out_valid drops immediately, counters reach 0, and the next full row reports out_row_idx=0.
- Row index wrap: IDX_W=4, stream 17 rows of four 1s → out_row_idx runs 0..15 then 0; every out_row_sum=4.
